// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the SRAM-backed MEM-stage responder.
package arm_mem_pkg;

    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        StIdle,
        StLo,
        StHi,
        StDone
    } mem_state_e;

    // Halfword address = 2 * word index of (addr - base) + half select; caller truncates.
    function automatic logic [WORD_W-1:0] sram_hw_addr(input logic [WORD_W-1:0] addr,
                                                       input logic [WORD_W-1:0] base,
                                                       input logic hi);
        return (((addr - base) >> 2) << 1) | WORD_W'(hi);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: load clears to zero, count advances until it reaches the limit.
module sram_wait_counter
    import arm_mem_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == limit_i);

endmodule

// File: rtl/sram_mem_responder.sv
// MEM-stage load/store responder over a 16-bit async SRAM; each word is two halfword phases.
// Defining READ_BUFFER_EN adds a single-entry read buffer giving zero-stall hits.
module sram_mem_responder
    import arm_mem_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned       SRAM_AW     = 18,
    parameter int unsigned       WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [WORD_W-1:0]  address,
    input  logic [WORD_W-1:0]  wdata,
    output logic [WORD_W-1:0]  rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int unsigned IdxW = SRAM_AW - 1;
    localparam logic [CNT_W-1:0] WaitLimit = CNT_W'(WAIT_CYCLES);

    mem_state_e          state_q;
    logic                wr_q;
    logic [IdxW-1:0]     idx_q;
    logic [SRAM_DW-1:0]  wdata_hi_q;
    logic [WORD_W-1:0]   rdata_q;

    logic                req;
    logic [IdxW-1:0]     req_idx;
    logic                start;
    logic                cnt_load;
    logic                cnt_en;
    logic                cnt_done;
    logic                buf_hit;
    logic [WORD_W-1:0]   hit_data;

    assign req     = mem_r_en | mem_w_en;
    assign req_idx = IdxW'(sram_hw_addr(address, BASE_ADDR, 1'b0) >> 1);
    assign start   = (state_q == StIdle) && req && !buf_hit;

    assign cnt_load = start || ((state_q == StLo) && cnt_done);
    assign cnt_en   = ((state_q == StLo) || (state_q == StHi)) && !cnt_done;

    sram_wait_counter u_wait_counter (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .limit_i(WaitLimit),
        .done_o (cnt_done)
    );

`ifdef READ_BUFFER_EN
    logic                buf_valid_q;
    logic [IdxW-1:0]     buf_tag_q;
    logic [WORD_W-1:0]   buf_data_q;
    logic [SRAM_DW-1:0]  wdata_lo_q;

    assign buf_hit  = (state_q == StIdle) && mem_r_en && !mem_w_en && buf_valid_q &&
                      (buf_tag_q == req_idx);
    assign hit_data = buf_data_q;

    // Misses fill at DONE; a store to the buffered word refreshes its data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            wdata_lo_q  <= '0;
        end else begin
            if (start) begin
                wdata_lo_q <= wdata[SRAM_DW-1:0];
            end
            if (state_q == StDone) begin
                if (!wr_q) begin
                    buf_valid_q <= 1'b1;
                    buf_tag_q   <= idx_q;
                    buf_data_q  <= rdata_q;
                end else if (buf_valid_q && (buf_tag_q == idx_q)) begin
                    buf_data_q <= {wdata_hi_q, wdata_lo_q};
                end
            end
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign hit_data = '0;
`endif

    assign rdata = buf_hit ? hit_data : rdata_q;

    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            StIdle:  ready = !req || buf_hit;
            StDone:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
        if (!rst) begin
            ready = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            wdata_hi_q  <= '0;
            rdata_q     <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (buf_hit) begin
                        rdata_q <= hit_data;
                    end else if (req) begin
                        // Write wins when both enables are high.
                        state_q     <= StLo;
                        wr_q        <= mem_w_en;
                        idx_q       <= req_idx;
                        wdata_hi_q  <= wdata[WORD_W-1:SRAM_DW];
                        sram_addr   <= {req_idx, 1'b0};
                        sram_dq_out <= wdata[SRAM_DW-1:0];
                        sram_dq_oe  <= mem_w_en;
                        sram_we_n   <= !mem_w_en;
                    end
                end
                StLo: begin
                    if (cnt_done) begin
                        state_q     <= StHi;
                        sram_addr   <= {idx_q, 1'b1};
                        sram_dq_out <= wdata_hi_q;
                        if (!wr_q) begin
                            rdata_q[SRAM_DW-1:0] <= sram_dq_in;
                        end
                    end
                end
                StHi: begin
                    if (cnt_done) begin
                        state_q    <= StDone;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (!wr_q) begin
                            rdata_q[WORD_W-1:SRAM_DW] <= sram_dq_in;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_mem_responder.md
Name: sram_mem_responder

Overview:
- Responder end of the MEM-stage data-memory interface. Serves the pipeline's 32-bit load/store requests (mem_r_en / mem_w_en) from an external 16-bit asynchronous SRAM.
- Each 32-bit word takes two halfword accesses, each lasting a programmable number of wait cycles.
- ready drops while an access is in flight. The top level ORs ~ready into freeze so that IF/ID/EXE/MEM hold.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM halfword 0.
- SRAM_AW, 18: SRAM halfword address width.
- WAIT_CYCLES, 1: extra cycles each halfword phase is held (range 0–15).

Ports:
- clk, input, 1: clock, all flops rise-edge.
- rst, input, 1: reset; asynchronous, active-low.
- mem_r_en, input, 1: load request; held stable until ready=1.
- mem_w_en, input, 1: store request; held stable until ready=1.
- address, input, 32: byte address; bits [1:0] ignored.
- wdata, input, 32: store data.
- rdata, output, 32: load data; valid while ready=1 after a read.
- ready, output, 1: 1 = no access pending, or the current access completes this cycle.
- sram_addr, output, SRAM_AW: halfword address.
- sram_dq_out, output, 16: write data to SRAM.
- sram_dq_in, input, 16: read data from SRAM.
- sram_dq_oe, output, 1: 1 = drive sram_dq_out onto the bus (pad tristate at top).
- sram_we_n, output, 1: active-low write enable.

Behaviour:
- Reset (async, rst=0): state IDLE, wait counter 0, rdata 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1, ready 1.
  - Reset asserted mid-access aborts the access immediately: sram_we_n returns to 1 asynchronously.
- Offset computation:
  - off = address - BASE_ADDR, 32-bit modulo.
  - word index = off[SRAM_AW:2], truncated, so the address wraps modulo 2^(SRAM_AW+1) bytes.
  - Low half: sram_addr = {index, 0}. High half: {index, 1}.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE, no request: ready=1.
  - IDLE, (mem_r_en | mem_w_en): ready=0; go to LO, counter=0.
  - Both enables high: treated as a write (write priority).
  - LO: sram_addr = low-half address. Stay WAIT_CYCLES+1 cycles, counter counts 0..WAIT_CYCLES, then go to HI.
    - Write: sram_we_n=0, sram_dq_oe=1, sram_dq_out=wdata[15:0] for every LO cycle.
    - Read: sram_we_n=1, sram_dq_oe=0; rdata[15:0] captured from sram_dq_in on the last LO cycle.
  - HI: same as LO for the high half, using wdata[31:16] / rdata[31:16]. Then go to DONE.
  - DONE: ready=1 for exactly one cycle, sram_we_n=1, sram_dq_oe=0, rdata stable. Go to IDLE.
  - A request still asserted in the cycle after DONE is a new access.
- Latency, miss: ready is low for 2*WAIT_CYCLES+2 cycles after the request is first seen; ready=1 on the following cycle. With WAIT_CYCLES=1: 4 low, 1 high.
- Request changing while ready=0 is a protocol violation: ignored, and the latched command completes.
- ready is combinational from state (+ request in IDLE); all SRAM pins are registered.
- Between the two halves sram_we_n stays 0 for writes. The address changes on the same edge; the SRAM part tolerates this.
- rdata is updated only by reads and holds its value otherwise.

Optional Feature:
- READ_BUFFER_EN defined: adds a single-entry read buffer holding a tag (word index), valid bit, and data.
  - Read hit in IDLE: ready=1 in the same cycle, rdata muxed from the buffer, no SRAM access, zero stall.
  - Miss fills the buffer at DONE.
  - Write to the buffered index updates the buffer data at DONE.
  - Reset clears valid.
- Undefined: no buffer; every read takes the full miss latency.

Decomposition:
- Package arm_mem_pkg:
  - state enum (IDLE/LO/HI/DONE)
  - SRAM_DW=16 and WORD_W=32 constants
  - default BASE_ADDR
  - helper function for the address-to-halfword-address mapping
- One sub-module, sram_wait_counter: 4-bit load/count with done flag, instantiated once.

Test Plan:
- Reset: rst=0 mid-write with sram_we_n=0 → sram_we_n=1, ready=1, rdata=0 without waiting for clk.
- Store then load, WAIT_CYCLES=1:
  - store address=1028, wdata=0xDEADBEEF → sram_addr 2 gets 0xBEEF and 3 gets 0xDEAD; ready low 4 cycles.
  - Subsequent load → rdata=0xDEADBEEF on the ready cycle.
- Simultaneous r/w: mem_r_en=mem_w_en=1, address=1032, wdata=0x12345678 → treated as a write; memory word = 0x12345678, sram_dq_oe=1 in LO and HI.
- WAIT_CYCLES=0 and 3 → ready low exactly 2 and 8 cycles respectively; back-to-back loads each incur full latency.
- Wrap: address=BASE_ADDR+2^19 → sram_addr 0/1 accessed; address=1026 → same word as 1024.
- READ_BUFFER_EN:
  - Load 1024 twice → second load has ready=1 with no stall and no SRAM activity.
  - Store 0xCAFEF00D to 1024, then load → 0xCAFEF00D returned with no stall.
